// File: rtl/ps2_key_tracker.sv
// PS/2 scancode tracker: decodes make/break/extended prefixes, keeps shift,
// caps-lock and Thai-layer state, and produces the character ROM address.
module ps2_key_tracker #(
  parameter logic [7:0] SHIFT_L_CODE = 8'h12,
  parameter logic [7:0] SHIFT_R_CODE = 8'h59,
  parameter logic [7:0] CAPS_CODE    = 8'h58,
  parameter logic [7:0] LANG_CODE    = 8'h0E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [9:0] addr,
  output logic       key_tick,
  output logic       rom_valid,
  output logic       shift,
  output logic       caps,
  output logic       thai
);

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int         N_DISCARD  = 6;

  // Keyboard status/ack bytes that carry no key information.
  localparam logic [7:0] DISCARD_CODES [N_DISCARD] =
    '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t     state_reg;
  logic [9:0] addr_reg;
  logic       key_tick_reg;
  logic       rom_valid_reg;
  logic       caps_reg;
  logic       thai_reg;
  logic       shift_l_held_reg;
  logic       shift_r_held_reg;
  logic       caps_held_reg;
  logic       lang_held_reg;

  logic [N_DISCARD-1:0] discard_hit;
  logic                 is_discard;
  logic                 shift_any;

  genvar gi;
  generate
    for (gi = 0; gi < N_DISCARD; gi++) begin : g_discard
      assign discard_hit[gi] = (rx_data == DISCARD_CODES[gi]);
    end
  endgenerate

  assign is_discard = |discard_hit;
  assign shift_any  = shift_l_held_reg | shift_r_held_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      key_tick_reg     <= 1'b0;
      rom_valid_reg    <= 1'b0;
      caps_reg         <= 1'b0;
      thai_reg         <= 1'b0;
      shift_l_held_reg <= 1'b0;
      shift_r_held_reg <= 1'b0;
      caps_held_reg    <= 1'b0;
      lang_held_reg    <= 1'b0;
    end else begin
      key_tick_reg  <= 1'b0;
      // The ROM registers addr on the key_tick cycle, so its data lands one cycle later.
      rom_valid_reg <= key_tick_reg;
      if (rx_done_tick) begin
        case (state_reg)
          IDLE: begin
            if (rx_data == PREFIX_EXT) begin
              state_reg <= EXT;
            end else if (rx_data == PREFIX_BRK) begin
              state_reg <= BRK;
            end else if (!is_discard) begin
              if (rx_data == SHIFT_L_CODE) begin
                shift_l_held_reg <= 1'b1;
              end else if (rx_data == SHIFT_R_CODE) begin
                shift_r_held_reg <= 1'b1;
              end else if (rx_data == CAPS_CODE) begin
                // Held flag suppresses re-toggling on typematic repeats.
                if (!caps_held_reg) begin
                  caps_reg      <= ~caps_reg;
                  caps_held_reg <= 1'b1;
                end
              end else if (rx_data == LANG_CODE) begin
                if (!lang_held_reg) begin
                  thai_reg      <= ~thai_reg;
                  lang_held_reg <= 1'b1;
                end
              end else begin
                addr_reg     <= {thai_reg, shift_any ^ caps_reg, rx_data};
                key_tick_reg <= 1'b1;
              end
            end
          end
          BRK: begin
            if (rx_data == SHIFT_L_CODE) shift_l_held_reg <= 1'b0;
            if (rx_data == SHIFT_R_CODE) shift_r_held_reg <= 1'b0;
            if (rx_data == CAPS_CODE)    caps_held_reg    <= 1'b0;
            if (rx_data == LANG_CODE)    lang_held_reg    <= 1'b0;
            state_reg <= IDLE;
          end
          EXT: begin
            // Extended keys (including the E0 12 fake shift) are not translated.
            state_reg <= (rx_data == PREFIX_BRK) ? EXT_BRK : IDLE;
          end
          EXT_BRK: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign addr      = addr_reg;
  assign key_tick  = key_tick_reg;
  assign rom_valid = rom_valid_reg;
  assign shift     = shift_any;
  assign caps      = caps_reg;
  assign thai      = thai_reg;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits directly upstream of the scancode-to-character ROM.
- Consumes the byte stream from the PS/2 receiver and decodes the make, break and extended prefixes.
- Tracks the shift, caps-lock and Thai-layer modifier state.
- Emits the 10-bit ROM address {thai, upper, scancode} with a one-cycle key-press strobe, plus a delayed strobe aligned with the ROM's registered output.

Parameters:
- SHIFT_L_CODE, 8'h12, left-shift scancode
- SHIFT_R_CODE, 8'h59, right-shift scancode
- CAPS_CODE, 8'h58, caps-lock scancode
- LANG_CODE, 8'h0E, language-toggle key (grave/tilde)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a complete received byte
- rx_data  in  8  received PS/2 byte
- addr  out  10  ROM address: [9]=thai, [8]=upper, [7:0]=scancode
- key_tick  out  1  one-cycle pulse, coincident with a new addr
- rom_valid  out  1  key_tick delayed 1 cycle; ROM data is valid in this cycle
- shift  out  1  left-held OR right-held
- caps  out  1  caps-lock toggle state
- thai  out  1  language-layer toggle state

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE; addr=0, key_tick=0, rom_valid=0, caps=0, thai=0, both shift-held flags=0, caps_held=0, lang_held=0.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen). Transitions happen only on rx_done_tick.
- IDLE transitions:
  - 8'hE0 -> EXT.
  - 8'hF0 -> BRK.
  - 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF -> discarded, stay IDLE.
  - Any other byte is a make code, handled per the make-code rules; stay IDLE.
- BRK: the next byte is a break code; apply the release rules, -> IDLE.
- EXT: 8'hF0 -> EXT_BRK. Any other byte is discarded (extended keys and E0 12 fake-shift are not translated; no tick) -> IDLE.
- EXT_BRK: the next byte is discarded -> IDLE.
- Make-code rules:
  - SHIFT_L/SHIFT_R: set the corresponding held flag; no tick.
  - CAPS_CODE: if caps_held=0, toggle caps and set caps_held; no tick. Typematic repeats do not re-toggle.
  - LANG_CODE: if lang_held=0, toggle thai and set lang_held; no tick.
  - Otherwise: addr <= {thai, shift^caps, rx_data}; key_tick=1 for one cycle. Typematic repeats of the same code emit a tick each time.
- Release rules:
  - SHIFT_L/SHIFT_R: clear the corresponding held flag.
  - CAPS_CODE: clear caps_held.
  - LANG_CODE: clear lang_held.
  - Other codes: no effect. Break codes never emit a tick.
- Modifier bits in addr are sampled from the state before the current byte is applied.
- Latency: rx_done_tick in cycle N -> addr updated and key_tick=1 in N+1 -> rom_valid=1 in N+2. The ROM registers addr at the end of N+1, so its data is valid in N+2.
- addr holds its last value between ticks. key_tick and rom_valid are never high for two consecutive cycles from a single byte.
- rx_done_tick while key_tick is high: processed normally. Back-to-back ticks on consecutive cycles are legal and must each be handled.
- Reset mid-prefix (e.g. after F0): the FSM returns to IDLE, so the next byte is treated as a make code.
- A break whose make was never seen: modifier flags are cleared unconditionally; no error.

Test Plan:
- Reset, then bytes 1C -> key_tick once with addr=10'h01C; rom_valid one cycle later; bytes F0 1C -> no tick, FSM back in IDLE.
- Bytes 12, 1C, F0 1C, F0 12, 1C -> ticks with addr=10'h11C then 10'h01C; shift=1 only between 12 and F0 12.
- Bytes 58, 58, F0 58, 15 -> caps=1 (the repeat does not re-toggle), tick addr=10'h115; then 12, 15 -> addr=10'h015 (shift XOR caps).
- Bytes 0E, F0 0E, 1C, 59, 1C -> thai=1; ticks addr=10'h21C then 10'h31C; right shift alone sets upper.
- Bytes E0 75, E0 F0 75, E0 12, AA, FA -> no key_tick at all, shift stays 0, FSM ends in IDLE.
- Bytes F0, then reset asserted for 1 cycle, then 1C -> all outputs cleared during reset; tick addr=10'h01C after reset.
